// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader_pkg
//  Description : Shared types and constants for the instruction memory
//                loader and the 8-bit core it feeds. Holds the default
//                address and instruction widths, the NOP encoding and the
//                loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_loader_pkg;

  // Default widths, shared with the core's fetch port.
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Instruction returned for any address outside the resident program.
  localparam logic [7:0] c_nop = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage : instr_mem_loader_pkg
`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader_if
//  Description : Program-load interface: a length-qualified start request,
//                a valid/ready byte stream, and load status.
//  Ports       : master = program source, slave = loader.
//                load_start/load_len : start request and length (1..DEPTH)
//                load_valid/load_data/load_ready : byte stream handshake
//                load_done  : one-cycle completion pulse
//                load_count : bytes accepted in current/last load
//                err_len    : sticky illegal-length flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              err_len;

  modport master (
    output load_start, load_len, load_valid, load_data,
    input  load_ready, load_done, load_count, err_len
  );

  modport slave (
    input  load_start, load_len, load_valid, load_data,
    output load_ready, load_done, load_count, err_len
  );
endinterface : instr_mem_loader_if
`default_nettype wire

// File: rtl/instr_mem_loader_ram.sv
`default_nettype none
// ============================================================================
//  Module      : instr_ram
//  Description : DEPTH x DATA_W program RAM, synchronous write port and
//                asynchronous read port. Contents are not reset.
//  Ports       : clock            - write clock
//                we/waddr/wdata   - write port
//                raddr/rdata      - combinational read port
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  wire logic              clock,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : instr_ram
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Instruction memory and program loader for the 8-bit core.
//                Receives a program as a byte stream, stores it in RAM,
//                then releases the core and serves instructions for its
//                fetch address. Addresses beyond the program read as NOP.
//  Ports       : clock        - system clock, rising edge
//                reset        - asynchronous, active-low reset
//                load         - program-load interface (slave side)
//                core_hold    - high while the core must stay in reset
//                read_address - core fetch address
//                Instruction  - instruction for read_address
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 256,
  parameter int REG_OUT = 0
) (
  input  wire logic              clock,
  input  wire logic              reset,
  instr_mem_loader_if.slave      load,
  output logic                   core_hold,
  input  wire logic [ADDR_W-1:0] read_address,
  output logic      [DATA_W-1:0] Instruction
);

  localparam logic [1:0]        c_st_idle = ST_IDLE;
  localparam logic [1:0]        c_st_load = ST_LOAD;
  localparam logic [1:0]        c_st_run  = ST_RUN;
  localparam logic [ADDR_W:0]   c_len_one = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   c_len_max = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);
  localparam logic [DATA_W-1:0] c_nop_w   = DATA_W'(c_nop);

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_prog_len;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_load_count;
  logic              r_load_ready;
  logic              r_load_done;
  logic              r_err_len;

  logic              w_len_legal;
  logic              w_xfer;
  logic [ADDR_W:0]   w_count_inc;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [DATA_W-1:0] w_rd_sel;

  assign w_len_legal = (load.load_len != '0) && (load.load_len <= c_len_max);
  assign w_xfer      = (r_state == c_st_load) && load.load_valid && r_load_ready;
  assign w_count_inc = r_load_count + c_len_one;

  // Loader FSM. load_start is only honoured in IDLE and RUN, so a request
  // coinciding with the final transfer of a load is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= c_st_idle;
      r_prog_len   <= '0;
      r_wptr       <= '0;
      r_load_count <= '0;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        c_st_idle, c_st_run: begin
          if (load.load_start) begin
            if (w_len_legal) begin
              r_prog_len   <= load.load_len;
              r_wptr       <= '0;
              r_load_count <= '0;
              r_err_len    <= 1'b0;
              r_load_ready <= 1'b1;
              r_state      <= c_st_load;
            end else begin
              r_err_len <= 1'b1;
            end
          end
        end
        c_st_load: begin
          if (w_xfer) begin
            // wptr wraps to 0 only on the 256th byte, which ends the load.
            r_wptr       <= r_wptr + c_ptr_one;
            r_load_count <= w_count_inc;
            if (w_count_inc == r_prog_len) begin
              r_load_ready <= 1'b0;
              r_load_done  <= 1'b1;
              r_state      <= c_st_run;
            end
          end
        end
        default: begin
          r_load_ready <= 1'b0;
          r_state      <= c_st_idle;
        end
      endcase
    end
  end

  instr_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (w_xfer),
    .waddr (r_wptr),
    .wdata (load.load_data),
    .raddr (read_address),
    .rdata (w_ram_rdata)
  );

  // Stale bytes above the current program length must never reach the core.
  assign w_rd_sel = ((r_state == c_st_run) && ({1'b0, read_address} < r_prog_len))
                    ? w_ram_rdata : c_nop_w;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [DATA_W-1:0] r_instr;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_instr <= '0;
        end else begin
          r_instr <= w_rd_sel;
        end
      end
      // Gate with state so the output drops to NOP the moment RUN is left.
      assign Instruction = (r_state == c_st_run) ? r_instr : c_nop_w;
    end else begin : g_comb_out
      assign Instruction = w_rd_sel;
    end
  endgenerate

  assign core_hold       = (r_state != c_st_run);
  assign load.load_ready = r_load_ready;
  assign load.load_done  = r_load_done;
  assign load.load_count = r_load_count;
  assign load.err_len    = r_err_len;

endmodule : instr_mem_loader
`default_nettype wire

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Instruction memory and program loader feeding the 8-bit core `main`.
- Accepts a program as a byte stream over a valid/ready handshake and stores it in a 256x8 RAM.
- Then releases the core and serves `Instruction` for the core's `read_address`.
- Holds the core off (core_hold) while no valid program is resident.

Parameters:
- ADDR_W, 8, instruction address width; matches core `read_address`.
- DATA_W, 8, instruction width.
- DEPTH, 256, memory depth; equals 2**ADDR_W.
- REG_OUT, 0, instruction read mode:
  - 0 = combinational read (same-cycle `Instruction`).
  - 1 = registered read (1-cycle latency).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  request to begin a program load.
- load_len  in  ADDR_W+1  program length in bytes, valid 1..DEPTH; sampled with load_start.
- load_valid  in  1  load_data holds a valid byte.
- load_data  in  DATA_W  program byte.
- load_ready  out  1  loader accepts a byte this cycle.
- load_done  out  1  one-cycle pulse, program fully loaded.
- load_count  out  ADDR_W+1  bytes accepted in current or last load.
- err_len  out  1  sticky: load_start with illegal length; cleared by the next legal load_start.
- core_hold  out  1  high = core must be held in reset.
- read_address  in  ADDR_W  fetch address from core.
- Instruction  out  DATA_W  instruction for read_address.

Behaviour:
- Reset (async, reset=0) values:
  - state=IDLE; core_hold=1; load_ready=0; load_done=0; load_count=0; err_len=0; Instruction=0.
  - Internal prog_len=0.
  - RAM contents are not cleared.
- State machine: IDLE, LOAD, RUN.
- IDLE:
  - core_hold=1; Instruction=0.
  - On load_start with 1<=load_len<=DEPTH: latch prog_len, wptr=0, load_count=0, err_len=0, go to LOAD.
  - On load_start with load_len=0 or >DEPTH: err_len=1, stay in IDLE.
- LOAD:
  - load_ready=1 (registered; asserts the cycle after entering LOAD).
  - Transfer occurs when load_valid && load_ready: RAM[wptr]<=load_data, wptr++, load_count++.
  - Gaps in load_valid are allowed; nothing is written on those cycles.
  - On the transfer making load_count==prog_len:
    - load_ready drops the next cycle.
    - load_done pulses for exactly 1 cycle (the cycle after the last transfer).
    - State goes to RUN in that same cycle; core_hold=0 from that cycle onward.
  - load_start is ignored in LOAD.
- RUN:
  - Instruction = (read_address < prog_len) ? RAM[read_address] : 8'h00 (NOP).
  - Addresses at or beyond prog_len always read NOP, even if stale data from an earlier load exists.
  - REG_OUT=0: combinational from read_address.
  - REG_OUT=1: registered, valid one cycle after the address is presented.
  - load_start with a legal length: re-enter LOAD, core_hold=1 in the next cycle, prog_len updated, Instruction=0 while loading.
  - load_start with an illegal length: err_len=1, stay in RUN.
- Width rules:
  - load_count and prog_len are ADDR_W+1 bits so that 256 is representable.
  - wptr is ADDR_W bits; its wrap at 256 coincides with load completion and is never used for a write.
- Simultaneous events: load_start in the same cycle as the final LOAD transfer is ignored.
- Reset mid-load:
  - Immediate return to IDLE; prog_len=0; core_hold=1.
  - Partially written bytes remain in RAM but are unreachable until the next load completes.
- Reads are performed only in RUN. Outside RUN, Instruction is forced to 0 regardless of read_address.

Decomposition:
- Shared package:
  - state enum {IDLE, LOAD, RUN}.
  - NOP constant 8'h00.
  - ADDR_W/DATA_W defaults, shared with `main`.
- One sub-module, instr_ram:
  - DEPTH x DATA_W.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
- The loader FSM and output muxing/registering stay in instr_mem_loader.

Test Plan:
- Reset check: drive reset=0 for 3 cycles, then release -> core_hold=1, load_ready=0, Instruction=00, load_count=0, err_len=0.
- Basic load with gaps: load_len=4, bytes A1,B2,C3,D4 with one idle cycle between B2 and C3.
  - load_done pulses once, exactly 1 cycle after D4 is accepted.
  - core_hold=0; read_address 0..3 -> A1,B2,C3,D4; read_address 4 -> 00.
  - Repeat with REG_OUT=1 and check 1-cycle latency.
- Illegal length: load_start with load_len=0, then with load_len=257 -> err_len=1, state stays IDLE, load_ready=0.
  - Follow with a legal load_start -> err_len clears.
- Full depth: load_len=256, data=address^8'h5A -> load_count=256, load_done pulse; read_address FF -> A5, 00 -> 5A.
- Reset mid-load: load_len=4, accept 2 bytes, then pulse reset=0.
  - Result: IDLE, core_hold=1, Instruction=00, load_count=0.
  - Next load with load_len=1 -> address 1 reads 00.
- Reload shrink: after a 4-byte program in RUN, load_start with load_len=2 (bytes 11,22).
  - core_hold=1 during the load, then 0.
  - read_address 0,1 -> 11,22; read_address 2,3 -> 00 despite stale C3,D4 in RAM.
